shared_ram_arbiter: RTL
=======================

Name: shared_ram_arbiter

Overview:
- Round-robin arbiter that shares one port of the 32-bit byte-enabled shared RAM between two PicoRV32-native-bus requesters (m0, m1), e.g. the RISC-V core and a DMA/debug master.
- Sequences each access through a three-state FSM sized for the RAM's one-cycle synchronous read latency.
- Returns a single-cycle ready pulse and read data to the granted requester only.

Parameters:
- ADDR_WIDTH, 6, word-address width of the RAM port and of both requester address inputs.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- m0_valid  input  1  requester 0 access request; held until m0_ready
- m0_ready  output  1  requester 0 access complete (one-cycle pulse)
- m0_addr  input  ADDR_WIDTH  requester 0 word address
- m0_wdata  input  32  requester 0 write data
- m0_wstrb  input  4  requester 0 byte write enables; 0 = read
- m0_rdata  output  32  requester 0 read data
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0, for requester 1
- ram_valid  output  1  RAM port enable
- ram_addr  output  ADDR_WIDTH  RAM port address
- ram_wdata  output  32  RAM port write data
- ram_we  output  4  RAM port byte write enables
- ram_q  input  32  RAM port read data, registered by RAM one cycle after address

Behaviour:
- Reset values: state=IDLE, grant=0, last_grant=1, all outputs 0.
- FSM states: IDLE, ACCESS, RESP. grant selects which requester drives the RAM mux.
- IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: grant <= that requester; go to ACCESS.
  - Both valid: grant <= ~last_grant; go to ACCESS. Reset value 1 makes m0 win the first tie.
  - last_grant <= new grant whenever entering ACCESS.
- ACCESS (one cycle):
  - ram_valid=1.
  - ram_addr, ram_wdata come from the granted requester.
  - ram_we = granted wstrb & {4{granted valid}}.
  - Granted valid high: go to RESP.
  - Granted valid low (aborted request): go to IDLE; no ready; no write (we gated to 0).
- RESP (one cycle):
  - granted mX_ready=1; mX_rdata=ram_q.
  - Go to IDLE.
  - Write accesses also pulse ready; rdata = ram_q (don't-care to the requester).
- Outside RESP, or for the non-granted requester: ready=0, rdata=0.
- Outside ACCESS: ram_valid=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Outputs are combinational decodes of the state and grant registers plus the mux; no combinational path from mX_valid to mX_ready.
- Latency: valid sampled at edge k; ACCESS during cycle k+1; ready during cycle k+2. Minimum 3 cycles per access; maximum wait for a contending requester 6 cycles.
- A requester must deassert valid, or present a new request, after ready. A valid still high in the IDLE cycle after RESP counts as a new request.
- Starvation-free: a requester left waiting through one access wins the next tie.
- Reset asserted mid-access: FSM returns to IDLE immediately and ram_we drops asynchronously; the RAM write in flight is lost if reset precedes the ACCESS→RESP edge.

Optional Feature:
- SHARED_RAM_ARB_STATS_EN defined adds ports:
  - stat_clr  input  1  synchronous clear of all counters
  - stat_m0_grants  output  16
  - stat_m1_grants  output  16
  - stat_conflicts  output  16
- Counter behaviour:
  - Grant counters increment on each IDLE→ACCESS transition for the respective requester.
  - stat_conflicts increments on each IDLE cycle with both valids high.
  - All counters saturate at 16'hFFFF and reset to 0.
  - stat_clr has priority over increment.
- Macro undefined: ports and counters absent; core behaviour identical.

Test Plan:
- m0 write addr=5, wdata=32'hDEADBEEF, wstrb=4'hF, then read addr=5 -> ram_we=4'hF only in ACCESS cycle; m0_ready pulses cycle k+2 each time; m0_rdata=32'hDEADBEEF on the read; m1_ready stays 0.
- m1 byte write wstrb=4'b0010, wdata=32'h0000AB00, addr=3 over prior word 32'h11223344 -> subsequent read returns 32'h1122AB44.
- m0 and m1 both valid continuously from reset -> grants alternate m0,m1,m0,m1; each ready pulses once per 6 cycles; no ready coincides.
- m1 valid deasserted during its ACCESS cycle with wstrb=4'hF -> ram_we=0; FSM returns to IDLE; no m1_ready; RAM contents unchanged.
- resetn pulled low during ACCESS -> all outputs 0 within the same cycle; after release, the first tie grants m0.
- With SHARED_RAM_ARB_STATS_EN: 3 m0 accesses, 2 m1 accesses, 1 tie -> stat_m0_grants=3, stat_m1_grants=2, stat_conflicts≥1; stat_clr pulse -> all counters 0 next cycle.

Source files
------------

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM port between two native-bus requesters.
// Optional usage counters are compiled in when SHARED_RAM_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no access in flight; pick a requester from the current valids
// ACCESS | RAM port driven from the granted requester for one cycle
// RESP   | RAM read data available; ready pulsed to the granted requester
module shared_ram_arbiter #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic [31:0]           m1_rdata,
    output logic                  ram_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_we,
    input  logic [31:0]           ram_q
`ifdef SHARED_RAM_ARB_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           stat_m0_grants,
    output logic [15:0]           stat_m1_grants,
    output logic [15:0]           stat_conflicts
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   granted_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign granted_valid = grant_q ? m1_valid : m0_valid;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        m0_rdata     = 32'h0;
        m1_rdata     = 32'h0;
        ram_valid    = 1'b0;
        ram_addr     = '0;
        ram_wdata    = 32'h0;
        ram_we       = 4'h0;
        case (state_q)
            S_IDLE: begin
                if (m0_valid || m1_valid) begin
                    // on a tie the requester that lost last time wins
                    if (m0_valid && m1_valid)
                        grant_d = ~last_grant_q;
                    else
                        grant_d = m1_valid;
                    last_grant_d = grant_d;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_valid = 1'b1;
                ram_addr  = grant_q ? m1_addr  : m0_addr;
                ram_wdata = grant_q ? m1_wdata : m0_wdata;
                ram_we    = (grant_q ? m1_wstrb : m0_wstrb) & {4{granted_valid}};
                state_d   = granted_valid ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                if (grant_q) begin
                    m1_ready = 1'b1;
                    m1_rdata = ram_q;
                end else begin
                    m0_ready = 1'b1;
                    m0_rdata = ram_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SHARED_RAM_ARB_STATS_EN
    logic start_access;
    logic conflict;

    assign start_access = (state_q == S_IDLE) && (m0_valid || m1_valid);
    assign conflict     = (state_q == S_IDLE) && m0_valid && m1_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_m0_grants <= 16'h0;
            stat_m1_grants <= 16'h0;
            stat_conflicts <= 16'h0;
        end else if (stat_clr) begin
            stat_m0_grants <= 16'h0;
            stat_m1_grants <= 16'h0;
            stat_conflicts <= 16'h0;
        end else begin
            if (start_access && !grant_d && (stat_m0_grants != 16'hFFFF))
                stat_m0_grants <= stat_m0_grants + 16'd1;
            if (start_access && grant_d && (stat_m1_grants != 16'hFFFF))
                stat_m1_grants <= stat_m1_grants + 16'd1;
            if (conflict && (stat_conflicts != 16'hFFFF))
                stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule
